// File: rtl/washer_plant_model.sv
// washer_plant_model: cycle-level washing-machine plant (water level, drum speed, door lock, faults).
// Define WASHER_PLANT_LEAK_EN to add the leak_inj input and leak fault code 5.
module washer_plant_model #(
   parameter int TICK_DIV     = 1,
   parameter int LEVEL_MAX    = 100,
   parameter int FILL_RATE    = 4,
   parameter int DRAIN_RATE   = 5,
   parameter int SPIN_LVL_MAX = 10,
   parameter int WASH_RPM     = 40,
   parameter int RINSE_RPM    = 30,
   parameter int SPIN_RPM     = 200,
   parameter int RAMP_STEP    = 10,
   parameter int DOOR_DELAY   = 3,
   parameter int FILL_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       fill,
   input  logic       wash,
   input  logic       rinse,
   input  logic       spin,
   input  logic       drain,
   input  logic       fault_clr,
`ifdef WASHER_PLANT_LEAK_EN
   input  logic       leak_inj,
`endif
   output logic [7:0] water_level,
   output logic       level_full,
   output logic       level_empty,
   output logic [7:0] motor_rpm,
   output logic       at_speed,
   output logic       door_lock,
   output logic       fault,
   output logic [2:0] fault_code
);
   typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

   state_t      state_q;
   logic [15:0] tick_cnt_q;
   logic [7:0]  level_q, rpm_q, idle_cnt_q, fto_cnt_q;
   logic        at_speed_q, lock_q, fault_q;
   logic [2:0]  code_q;

   logic        tick, any_cmd, drum_off, fill_eff, down, idle, lock_d, at_speed_d;
   logic [1:0]  n_drum;
   logic [2:0]  det;
   logic [7:0]  level_d, target, rpm_d, idle_cnt_d, fto_cnt_d;

   always_comb begin
      tick    = (tick_cnt_q == 16'(TICK_DIV - 1));
      any_cmd = fill | wash | rinse | spin | drain;
      n_drum  = 2'(wash) + 2'(rinse) + 2'(spin);
      down    = drain | spin;

      // Lowest code wins; detection is suspended once a fault is latched.
      det = 3'd0;
      if (state_q != FAULT) begin
         if (n_drum > 2'd1 || (fill && spin))                    det = 3'd1;
         else if (spin && level_q > 8'(SPIN_LVL_MAX))            det = 3'd2;
         else if (wash && level_q == 8'd0)                       det = 3'd3;
         else if (fill && level_q == 8'(LEVEL_MAX) &&
                  fto_cnt_q >= 8'(FILL_TIMEOUT))                 det = 3'd4;
      end

      // The valve closes on the same tick a fault is detected.
      fill_eff = fill && (state_q != FAULT) && (det == 3'd0);
      level_d  = level_q;
      if (fill_eff && !down)
         level_d = (9'(level_q) + 9'(FILL_RATE) > 9'(LEVEL_MAX)) ? 8'(LEVEL_MAX)
                                                                : level_q + 8'(FILL_RATE);
      else if (down && !fill_eff)
         level_d = (level_q > 8'(DRAIN_RATE)) ? level_q - 8'(DRAIN_RATE) : 8'd0;
`ifdef WASHER_PLANT_LEAK_EN
      if (leak_inj && level_d != 8'd0) level_d = level_d - 8'd1;
      if (state_q != FAULT && det == 3'd0 && !down && level_d < level_q) det = 3'd5;
`endif
      drum_off = (state_q == FAULT) || (det != 3'd0);

      target = 8'd0;
      if (!drum_off) begin
         if (spin)       target = 8'(SPIN_RPM);
         else if (wash)  target = 8'(WASH_RPM);
         else if (rinse) target = 8'(RINSE_RPM);
      end
      rpm_d = rpm_q;
      if (rpm_q < target)
         rpm_d = (target - rpm_q > 8'(RAMP_STEP)) ? rpm_q + 8'(RAMP_STEP) : target;
      else if (rpm_q > target)
         rpm_d = (rpm_q - target > 8'(RAMP_STEP)) ? rpm_q - 8'(RAMP_STEP) : target;
      at_speed_d = (rpm_d == target) && (target != 8'd0);

      fto_cnt_d = 8'd0;
      if (!drum_off && fill && level_q == 8'(LEVEL_MAX))
         fto_cnt_d = (fto_cnt_q == 8'hFF) ? fto_cnt_q : fto_cnt_q + 8'd1;

      // Once unlocked the door stays unlocked while the plant remains idle.
      idle       = !any_cmd && rpm_q == 8'd0;
      idle_cnt_d = 8'd0;
      if (idle) idle_cnt_d = (idle_cnt_q == 8'hFF) ? idle_cnt_q : idle_cnt_q + 8'd1;
      lock_d = lock_q ? !(idle && idle_cnt_d >= 8'(DOOR_DELAY)) : !idle;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         tick_cnt_q <= 16'd0;
         level_q    <= 8'd0;
         rpm_q      <= 8'd0;
         idle_cnt_q <= 8'd0;
         fto_cnt_q  <= 8'd0;
         at_speed_q <= 1'b0;
         lock_q     <= 1'b0;
         fault_q    <= 1'b0;
         code_q     <= 3'd0;
      end else begin
         tick_cnt_q <= tick ? 16'd0 : tick_cnt_q + 16'd1;
         if (tick) begin
            level_q    <= level_d;
            rpm_q      <= rpm_d;
            at_speed_q <= at_speed_d;
            lock_q     <= lock_d;
            idle_cnt_q <= idle_cnt_d;
            fto_cnt_q  <= fto_cnt_d;
            if (det != 3'd0) begin
               state_q <= FAULT;
               fault_q <= 1'b1;
               code_q  <= det;
            end else begin
               case (state_q)
                  IDLE:  if (any_cmd) state_q <= RUN;
                  RUN:   if (!any_cmd && rpm_q == 8'd0) state_q <= IDLE;
                  FAULT: if (fault_clr && !any_cmd) begin
                     state_q <= IDLE;
                     fault_q <= 1'b0;
                     code_q  <= 3'd0;
                  end
                  default: state_q <= IDLE;
               endcase
            end
         end
      end
   end

   assign water_level = level_q;
   assign level_full  = (level_q == 8'(LEVEL_MAX));
   assign level_empty = (level_q == 8'd0);
   assign motor_rpm   = rpm_q;
   assign at_speed    = at_speed_q;
   assign door_lock   = lock_q;
   assign fault       = fault_q;
   assign fault_code  = code_q;
endmodule
